led_chase_ctrl: RTL

Sequencer that drives an 8-bit serial-in/parallel-out LED shift register to produce "fill left-to-right, then clear" chase patterns. It generates the serial data bit (s_in) and a one-cycle shift enable at a prescaled step rate. It sits between board buttons/switches and an enable-gated SIPO register whose parallel output drives the LEDs.

---
 rtl/led_pkg.sv | 19 +
 rtl/led_tick_gen.sv | 29 ++
 rtl/led_chase_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED chase sequencer: FSM state encoding and pattern modes.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    DOT   = 3'd4,
    FLUSH = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [1:0] MODE_FILL = 2'd0;
  localparam logic [1:0] MODE_LOOP = 2'd1;
  localparam logic [1:0] MODE_DOT  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: counts 0..DIV-1 and flags the last count as the step tick.
module led_tick_gen #(
  parameter int DIV = 25_000_000,
  parameter int CW  = $clog2(DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = (r_count == CW'(DIV - 1));
  assign o_tick = w_wrap;

  // prescaler counter, held at zero while cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/led_chase_ctrl.sv
// LED chase sequencer: drives serial data and a one-cycle shift strobe into an
// external enable-gated SIPO to produce fill/drain, looping and single-dot patterns.
module led_chase_ctrl
  import led_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 25_000_000,
  parameter int CW    = $clog2(DIV)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic [1:0]               i_mode,
  input  logic                     i_stop,
  input  logic                     i_abort,
  output logic                     o_s_in,
  output logic                     o_shift_en,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [$clog2(WIDTH)-1:0] o_step
);

  localparam int            SW   = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_step;
  logic [SW-1:0] w_step_nxt;
  logic [1:0]    r_mode_q;
  logic          r_stop_req;
  logic          r_s_in;
  logic          r_shift_en;
  logic          r_busy;
  logic          r_done;

  logic w_tick;
  logic w_clr;
  logic w_accept;
  logic w_abort_hit;
  logic w_last;
  logic w_loop_again;
  logic w_shift_en;
  logic w_s_in;
  logic w_done;

  assign w_clr        = (r_state == IDLE) || (r_state == FLUSH) || (r_state == DONE);
  assign w_accept     = (r_state == IDLE) && i_start && !i_abort;
  // FLUSH ignores a repeated abort so its shift count never restarts
  assign w_abort_hit  = i_abort && (r_state != IDLE) && (r_state != FLUSH);
  assign w_last       = (r_step == LAST);
  assign w_loop_again = (r_mode_q == MODE_LOOP) && !r_stop_req && !i_stop;

  led_tick_gen #(
    .DIV (DIV),
    .CW  (CW)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic; abort from any active phase has priority
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort_hit) begin
      w_state_nxt = FLUSH;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = !w_accept ? IDLE : ((i_mode == MODE_DOT) ? DOT : FILL);
        FILL:    w_state_nxt = (w_tick && w_last) ? HOLD : FILL;
        HOLD:    w_state_nxt = w_tick ? DRAIN : HOLD;
        DRAIN:   w_state_nxt = !(w_tick && w_last) ? DRAIN : (w_loop_again ? FILL : DONE);
        DOT:     w_state_nxt = (w_tick && w_last) ? DONE : DOT;
        FLUSH:   w_state_nxt = w_last ? IDLE : FLUSH;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // output and step decode; s_in is only ever high alongside a shift
  always_comb begin
    w_shift_en = 1'b0;
    w_s_in     = 1'b0;
    w_done     = 1'b0;
    w_step_nxt = r_step;
    if (w_abort_hit) begin
      w_step_nxt = '0;
    end else begin
      case (r_state)
        FILL, DRAIN: begin
          w_shift_en = w_tick;
          w_s_in     = w_tick && (r_state == FILL);
          w_step_nxt = !w_tick ? r_step : (w_last ? '0 : r_step + SW'(1));
        end
        DOT: begin
          w_shift_en = w_tick;
          w_s_in     = w_tick && (r_step == '0);
          w_step_nxt = !w_tick ? r_step : (w_last ? '0 : r_step + SW'(1));
        end
        FLUSH: begin
          w_shift_en = 1'b1;
          w_step_nxt = w_last ? '0 : r_step + SW'(1);
        end
        DONE: begin
          w_done     = 1'b1;
          w_step_nxt = '0;
        end
        default: begin
          w_step_nxt = '0;
        end
      endcase
    end
  end

  // sequence context and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step     <= '0;
      r_mode_q   <= 2'd0;
      r_stop_req <= 1'b0;
      r_s_in     <= 1'b0;
      r_shift_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_step     <= w_step_nxt;
      r_mode_q   <= w_accept ? i_mode : r_mode_q;
      if ((r_state == IDLE) || (r_state == FLUSH)) begin
        r_stop_req <= 1'b0;
      end else if (i_stop) begin
        r_stop_req <= 1'b1;
      end else begin
        r_stop_req <= r_stop_req;
      end
      r_s_in     <= w_s_in;
      r_shift_en <= w_shift_en;
      r_busy     <= (r_state != IDLE);
      r_done     <= w_done;
    end
  end

  assign o_s_in     = r_s_in;
  assign o_shift_en = r_shift_en;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_step     = r_step;

endmodule
